// File: rtl/rca_nibble_seq_ctrl.sv
// Wide adder that time-shares one 4-bit ripple-carry adder, one nibble per clock, LSB first.
// The inter-nibble carry is registered; busy/done decode directly from the state register.

module rca (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[4];

endmodule

module rca_nibble_seq_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] s,
   output logic                 co
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   // Encoding chosen so busy and done are each a single state flop.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    s_q, s_d;
   logic            co_q, co_d;

   logic [3:0]      nib_a;
   logic [3:0]      nib_b;
   logic [3:0]      nib_s;
   logic            nib_co;

   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IdxW'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
         end
      end
   end

   rca u_rca (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      co_d    = co_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               s_d     = '0;
               co_d    = 1'b0;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IdxW'(i)) begin
                  s_d[4*i +: 4] = nib_s;
               end
            end
            carry_d = nib_co;
            if (idx_q == LastIdx) begin
               co_d    = nib_co;
               idx_d   = '0;
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         co_q    <= co_d;
      end
   end

   assign busy = state_q[0];
   assign done = state_q[1];
   assign s    = s_q;
   assign co   = co_q;

endmodule

// File: tb/tb_rca_nibble_seq_ctrl.sv
// Self-checking bench: cycle-level model of the nibble-serial adder plus directed literal checks.

module tb_rca_nibble_seq_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         co;

   int checks = 0;
   int errors = 0;

   rca_nibble_seq_ctrl #(.NIBBLES(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .s       (s),
      .co      (co)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] low_mask(input int k);
      logic [W-1:0] one;
      one = 1;
      return (one << (4 * k)) - one;
   endfunction

   // Model: phase -1 idle, 0..N-1 nibbles completed while running, N = done cycle.
   int           phase = -1;
   logic [W:0]   op_sum = '0;
   logic [W-1:0] exp_s = '0;
   logic         exp_co = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase  = -1;
         exp_s  = '0;
         exp_co = 1'b0;
      end else if (phase < 0) begin
         if (start) begin
            op_sum = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            phase  = 0;
            exp_s  = '0;
            exp_co = 1'b0;
         end
      end else if (phase < N) begin
         phase++;
         exp_s = op_sum[W-1:0] & low_mask(phase);
         if (phase == N) exp_co = op_sum[W];
      end else begin
         phase = -1;
      end
   end

   logic prev_done = 1'b0;

   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(phase >= 0 && phase < N));
      chk("done", 64'(done), 64'(phase == N));
      chk("s", 64'(s), 64'(exp_s));
      chk("co", 64'(co), 64'(exp_co));
      chk("done_twice", 64'(done && prev_done), 64'(0));
      prev_done = done;
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic eco, input string name);
      int n;
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'(N + 1));
      chk({name, "_s"}, 64'(s), 64'(es));
      chk({name, "_co"}, 64'(co), 64'(eco));
   endtask

   initial begin
      logic [W-1:0] prog [4];
      int cyc, ops, last_acc;
      logic prev_busy;

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_s", 64'(s), 64'(0));
      reset_n = 1'b1;

      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "add_basic");
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple_b");
      run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple_cin");

      // Partial sums appear one nibble per cycle, LSB first.
      prog = '{16'h0001, 16'h0011, 16'h0111, 16'h1111};
      @(negedge clk);
      a = 16'h8888; b = 16'h8888; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("lsb_first_s0", 64'(s), 64'(0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("lsb_first_s", 64'(s), 64'(prog[k]));
      end
      chk("lsb_first_done", 64'(done), 64'(1));
      chk("lsb_first_co", 64'(co), 64'(1));

      // Starts during RUN and DONE are ignored.
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("ign_done", 64'(done), 64'(1));
      chk("ign_s", 64'(s), 64'(16'h0002));
      chk("ign_co", 64'(co), 64'(0));
      a = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy_after", 64'(busy), 64'(0));
      chk("ign_s_hold", 64'(s), 64'(16'h0002));

      // Asynchronous reset in the second RUN cycle.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_s", 64'(s), 64'(16'h0005));
      #1 reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_s", 64'(s), 64'(0));
      chk("arst_co", 64'(co), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "post_rst");

      // Start held high with operands changing every cycle.
      ops = 0;
      cyc = 0;
      last_acc = -1;
      prev_busy = busy;
      while (ops < 200 && cyc < 1400) begin
         @(negedge clk);
         cyc++;
         if (busy && !prev_busy) begin
            if (last_acc >= 0) chk("accept_spacing", 64'(cyc - last_acc), 64'(N + 2));
            last_acc = cyc;
         end
         prev_busy = busy;
         if (done) ops++;
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         start = 1'b1;
      end
      chk("held_ops", 64'(ops), 64'(200));
      start = 1'b0;
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_nibble_seq_ctrl.md
Name: rca_nibble_seq_ctrl

Overview:
Sequencer that performs wide (4*NIBBLES-bit) addition by time-sharing a single 4-bit ripple-carry adder, one nibble per clock from LSB to MSB. The carry is registered between nibbles. Sits between operand sources and the 7-segment display path; its s/co outputs feed seg_dec instances downstream. Instantiates the existing 4-bit rca (ports a, b, ci, s, co) exactly once.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; legal range 1..8.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  4*NIBBLES  operand A; sampled when start is accepted
b  input  4*NIBBLES  operand B; sampled when start is accepted
cin  input  1  carry-in to nibble 0; sampled when start is accepted
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse: result valid
s  output  4*NIBBLES  registered sum
co  output  1  registered carry-out of the MSB nibble

Behaviour:
- Reset: reset_n low asynchronously forces state=IDLE, busy=0, done=0, s=0, co=0, nibble index=0, carry reg=0, operand regs=0. Reset mid-RUN aborts the operation with no partial result retained.
- States: IDLE, RUN, DONE. The state register is the only source of busy and done; both are decoded registered state, glitch-free.
- IDLE:
  - start=1 at a rising edge latches a, b, cin into internal regs, clears s and co, sets idx=0, and goes to RUN.
  - start=0: stay in IDLE; s and co hold their previous values.
- RUN, one nibble per cycle:
  - rca inputs: a_reg[4*idx+3:4*idx], b_reg[4*idx+3:4*idx], ci=carry_reg.
  - carry_reg is loaded from cin at start accept.
  - At each edge: s[4*idx+3:4*idx] <= rca.s, carry_reg <= rca.co, idx <= idx+1.
  - When idx==NIBBLES-1, that edge also sets co <= rca.co and moves to DONE.
  - RUN lasts exactly NIBBLES cycles.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- Latency: start sampled at edge E0; busy=1 for cycles E0..E(NIBBLES); done=1 in the cycle after edge E(NIBBLES). Total NIBBLES+1 cycles from accept to done.
- start in RUN or DONE is ignored, with no queuing. A start held continuously is re-accepted on the first IDLE edge. Back-to-back throughput is one operation per NIBBLES+2 cycles.
- Operand changes on a/b/cin after accept have no effect on the running operation.
- Arithmetic: {co,s} == a + b + cin, modulo 2^(4*NIBBLES+1), exact.
- s and co remain stable from done until the next accepted start.
- idx width is clog2(NIBBLES), minimum 1. idx never exceeds NIBBLES-1.

Test Plan:
1. NIBBLES=4: a=0x1234, b=0x4321, cin=0, start pulse -> busy for 4 cycles, done on 5th cycle, s=0x5555, co=0.
2. a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 nibbles; s=0x0000, co=1. Also a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, co=1.
3. a=0x8888, b=0x8888, cin=1 -> s=0x1111, co=1. Check that per-nibble s updates appear LSB-first, one nibble per cycle.
4. Accept 0x0001+0x0001, then pulse start with a=0xFFFF during RUN and during DONE -> both ignored; result s=0x0002, co=0; busy/done timing unchanged.
5. Drive reset_n low asynchronously in the 2nd RUN cycle -> busy, done, s, co read 0 immediately without a clock edge. After release, a new start 0x00FF+0x0001 -> s=0x0100, co=0.
6. Hold start=1 continuously with randomized operands for 200 ops -> each done matches a+b+cin, accepts are spaced NIBBLES+2 cycles apart, and done is never high for two consecutive cycles.
